// File: rtl/letter_tx_scheduler_pkg.sv
// Shared definitions for the enigma letter path: letter width, buffer depth
// and the transmit scheduler state encoding.
package enigma_pkg;

    localparam int unsigned LETTER_W     = 5;
    localparam int unsigned LETTER_DEPTH = 1000;

    typedef logic [LETTER_W-1:0] letter_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SEND,
        WAIT_START,
        WAIT_DONE
    } tx_sched_state_t;

endpackage

// File: rtl/letter_tx_scheduler_if.sv
// Letter BRAM port addressing plus the ir_transmitter valid/busy handshake.
interface letter_tx_scheduler_if #(
    parameter int unsigned ADDR_W = 11
);
    logic              wr_valid_in;
    logic              wr_ready_out;
    logic              wr_en_out;
    logic [ADDR_W-1:0] wr_addr_out;
    logic [ADDR_W-1:0] rd_addr_out;
    logic              tx_valid_out;
    logic              tx_busy_in;

    modport master (
        input  wr_valid_in,
        input  tx_busy_in,
        output wr_ready_out,
        output wr_en_out,
        output wr_addr_out,
        output rd_addr_out,
        output tx_valid_out
    );

    modport slave (
        output wr_valid_in,
        output tx_busy_in,
        input  wr_ready_out,
        input  wr_en_out,
        input  wr_addr_out,
        input  rd_addr_out,
        input  tx_valid_out
    );
endinterface

// File: rtl/letter_tx_scheduler_wrap_counter.sv
// Modulo-DEPTH pointer with increment and synchronous clear; DEPTH need not
// be a power of two.
module wrap_counter #(
    parameter int unsigned DEPTH = 1000,
    parameter int unsigned W     = 11
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         clear_in,
    input  logic         inc_in,
    output logic [W-1:0] value_out
);

    logic [W-1:0] value_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            value_q <= '0;
        end else if (clear_in) begin
            value_q <= '0;
        end else if (inc_in) begin
            value_q <= (value_q == W'(DEPTH - 1)) ? '0 : value_q + 1'b1;
        end
    end

    assign value_out = value_q;

endmodule

// File: rtl/letter_tx_scheduler.sv
// Sequences stored letters from the letter BRAM to ir_transmitter: owns both
// BRAM pointers, occupancy, and the one-valid-per-letter busy handshake.
module letter_tx_scheduler
    import enigma_pkg::*;
#(
    parameter int unsigned DEPTH        = LETTER_DEPTH,
    parameter int unsigned ADDR_W       = 11,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned BUSY_TIMEOUT = 1024
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  clear_in,
    input  logic                  enable_in,
    letter_tx_scheduler_if.master tx_if,
    output logic [ADDR_W-1:0]     count_out,
    output logic                  full_out,
    output logic                  empty_out,
    output logic                  overflow_out,
    output logic                  timeout_out
);

    // FETCH and WAIT_START never overlap, so one timer serves both waits.
    localparam int unsigned TMR_MAX = (BUSY_TIMEOUT > READ_LATENCY) ? BUSY_TIMEOUT : READ_LATENCY;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    tx_sched_state_t   state, state_nxt;
    logic [TMR_W-1:0]  tmr_q, tmr_nxt;
    logic [ADDR_W-1:0] count_q;
    logic              overflow_q;
    logic              timeout_q;
    logic              wr_en;
    logic              pop;
    logic              to_fire;

    assign full_out  = (count_q == ADDR_W'(DEPTH));
    assign empty_out = (count_q == '0);
    assign wr_en     = tx_if.wr_valid_in && !full_out;

    wrap_counter #(.DEPTH(DEPTH), .W(ADDR_W)) u_wr_ptr (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .clear_in  (clear_in),
        .inc_in    (wr_en),
        .value_out (tx_if.wr_addr_out)
    );

    wrap_counter #(.DEPTH(DEPTH), .W(ADDR_W)) u_rd_ptr (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .clear_in  (clear_in),
        .inc_in    (pop),
        .value_out (tx_if.rd_addr_out)
    );

    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr_q;
        pop       = 1'b0;
        to_fire   = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable_in && !empty_out) begin
                    state_nxt = FETCH;
                    tmr_nxt   = '0;
                end
            end
            FETCH: begin
                if (tmr_q == TMR_W'(READ_LATENCY - 1)) begin
                    state_nxt = SEND;
                end else begin
                    tmr_nxt = tmr_q + 1'b1;
                end
            end
            SEND: begin
                pop       = 1'b1;
                tmr_nxt   = '0;
                state_nxt = WAIT_START;
            end
            WAIT_START: begin
                if (tx_if.tx_busy_in) begin
                    state_nxt = WAIT_DONE;
                end else if (tmr_q == TMR_W'(BUSY_TIMEOUT - 1)) begin
                    state_nxt = IDLE;
                    to_fire   = 1'b1;
                end else begin
                    tmr_nxt = tmr_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_if.tx_busy_in) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state      <= IDLE;
            tmr_q      <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else if (clear_in) begin
            state      <= IDLE;
            tmr_q      <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            tmr_q <= tmr_nxt;
            unique case ({wr_en, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (tx_if.wr_valid_in && full_out) begin
                overflow_q <= 1'b1;
            end
            if (to_fire) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign count_out          = count_q;
    assign overflow_out       = overflow_q;
    assign timeout_out        = timeout_q;
    assign tx_if.wr_ready_out = !full_out;
    assign tx_if.wr_en_out    = wr_en;
    assign tx_if.tx_valid_out = (state == SEND);

endmodule

// File: tb/tb_letter_tx_scheduler.sv
// Directed bench for letter_tx_scheduler with a simple ir_transmitter busy model.
module tb_letter_tx_scheduler;
    import enigma_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        clear_in;
    logic        enable_in;
    logic [10:0] count_out;
    logic        full_out, empty_out, overflow_out, timeout_out;

    int unsigned chk_cnt = 0;
    int unsigned err_cnt = 0;

    bit model_on   = 1'b1;
    int busy_delay = 2;
    int busy_len   = 50;

    letter_tx_scheduler_if #(.ADDR_W(11)) sif ();

    letter_tx_scheduler #(
        .DEPTH        (1000),
        .ADDR_W       (11),
        .READ_LATENCY (2),
        .BUSY_TIMEOUT (16)
    ) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .clear_in     (clear_in),
        .enable_in    (enable_in),
        .tx_if        (sif.master),
        .count_out    (count_out),
        .full_out     (full_out),
        .empty_out    (empty_out),
        .overflow_out (overflow_out),
        .timeout_out  (timeout_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_count"},    count_out, 0);
        check({tag, "_empty"},    empty_out, 1);
        check({tag, "_full"},     full_out, 0);
        check({tag, "_overflow"}, overflow_out, 0);
        check({tag, "_timeout"},  timeout_out, 0);
        check({tag, "_tx_valid"}, sif.tx_valid_out, 0);
        check({tag, "_wr_ready"}, sif.wr_ready_out, 1);
        check({tag, "_wr_addr"},  sif.wr_addr_out, 0);
        check({tag, "_rd_addr"},  sif.rd_addr_out, 0);
        check({tag, "_state"},    dut.state, IDLE);
    endtask

    // Holds wr_valid_in high across n rising edges, starting from a falling edge.
    task automatic write_burst(input int n);
        @(negedge clk_in);
        sif.wr_valid_in = 1'b1;
        repeat (n) @(negedge clk_in);
        sif.wr_valid_in = 1'b0;
    endtask

    // Six writes into an empty enabled buffer: the first is sent, five remain.
    task automatic fill_to_wait_done(input string tag);
        enable_in  = 1'b1;
        busy_delay = 2;
        busy_len   = 50;
        model_on   = 1'b1;
        write_burst(6);
        for (int i = 0; i < 30 && dut.state != WAIT_DONE; i++) @(negedge clk_in);
        check({tag, "_reach_wait_done"}, dut.state == WAIT_DONE, 1);
        check({tag, "_count5"}, count_out, 5);
    endtask

    // ir_transmitter stand-in: busy rises busy_delay cycles after the valid
    // cycle and stays high for busy_len cycles.
    initial begin
        sif.tx_busy_in = 1'b0;
        forever begin
            @(posedge clk_in);
            #1;
            if (model_on && sif.tx_valid_out) begin
                repeat (busy_delay) @(posedge clk_in);
                #1;
                sif.tx_busy_in = 1'b1;
                repeat (busy_len) @(posedge clk_in);
                #1;
                sif.tx_busy_in = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int sends;
        rst_in          = 1'b1;
        clear_in        = 1'b0;
        enable_in       = 1'b1;
        sif.wr_valid_in = 1'b0;
        repeat (2) @(negedge clk_in);
        check_reset_vals("rst");
        rst_in = 1'b0;

        // Single letter: valid in the cycle after edge t+3.
        @(negedge clk_in);
        sif.wr_valid_in = 1'b1;
        #1 check("t1_wr_en", sif.wr_en_out, 1);
        @(negedge clk_in);                              // after edge t
        sif.wr_valid_in = 1'b0;
        check("t1_count1", count_out, 1);
        check("t1_wr_addr", sif.wr_addr_out, 1);
        check("t1_idle", dut.state, IDLE);
        @(negedge clk_in);                              // after t+1
        check("t1_fetch", dut.state, FETCH);
        @(negedge clk_in);                              // after t+2
        check("t1_no_valid_yet", sif.tx_valid_out, 0);
        @(negedge clk_in);                              // after t+3
        check("t1_valid", sif.tx_valid_out, 1);
        check("t1_rd_addr", sif.rd_addr_out, 0);
        @(negedge clk_in);                              // after t+4
        check("t1_valid_once", sif.tx_valid_out, 0);
        check("t1_count0", count_out, 0);
        check("t1_empty", empty_out, 1);
        check("t1_rd_adv", sif.rd_addr_out, 1);
        check("t1_wait_start", dut.state, WAIT_START);
        for (int i = 0; i < 10 && dut.state != WAIT_DONE; i++) @(negedge clk_in);
        check("t1_wait_done", dut.state == WAIT_DONE, 1);
        for (int i = 0; i < 80 && sif.tx_busy_in; i++) @(negedge clk_in);
        check("t1_busy_fell", sif.tx_busy_in, 0);
        check("t1_still_wait_done", dut.state, WAIT_DONE);
        @(negedge clk_in);
        check("t1_back_idle", dut.state, IDLE);

        // Clear, then fill to DEPTH with sends paused, then one more write.
        enable_in = 1'b0;
        clear_in  = 1'b1;
        @(negedge clk_in);
        clear_in = 1'b0;
        check("clr_wr_addr", sif.wr_addr_out, 0);
        check("clr_rd_addr", sif.rd_addr_out, 0);
        write_burst(1000);
        check("fill_count", count_out, 1000);
        check("fill_full", full_out, 1);
        check("fill_ready", sif.wr_ready_out, 0);
        check("fill_wr_wrap", sif.wr_addr_out, 0);
        check("fill_no_ovf", overflow_out, 0);
        sif.wr_valid_in = 1'b1;
        #1 check("ovf_wr_en", sif.wr_en_out, 0);
        @(negedge clk_in);
        sif.wr_valid_in = 1'b0;
        check("ovf_flag", overflow_out, 1);
        check("ovf_wr_addr", sif.wr_addr_out, 0);
        check("ovf_count", count_out, 1000);

        // Drain all 1000 letters in order.
        busy_delay = 2;
        busy_len   = 3;
        enable_in  = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            for (int k = 0; k < 100 && !sif.tx_valid_out; k++) @(negedge clk_in);
            check("drain_send", {sif.tx_valid_out, sif.rd_addr_out}, {1'b1, 11'(i)});
            @(negedge clk_in);
        end
        for (int i = 0; i < 40 && dut.state != IDLE; i++) @(negedge clk_in);
        check("drain_idle", dut.state, IDLE);
        check("drain_empty", empty_out, 1);
        check("drain_rd_wrap", sif.rd_addr_out, 0);
        check("drain_count", count_out, 0);
        check("drain_ovf_sticky", overflow_out, 1);
        sends = 0;
        repeat (40) begin
            @(negedge clk_in);
            if (sif.tx_valid_out) sends++;
        end
        check("empty_no_send", sends, 0);

        // Write coinciding with the SEND pop, then busy never rises.
        model_on = 1'b0;
        @(negedge clk_in);
        sif.wr_valid_in = 1'b1;
        @(negedge clk_in);
        sif.wr_valid_in = 1'b0;
        for (int k = 0; k < 20 && !sif.tx_valid_out; k++) @(negedge clk_in);
        check("pop_send", sif.tx_valid_out, 1);
        check("pop_count_before", count_out, 1);
        sif.wr_valid_in = 1'b1;                         // in SEND cycle s
        @(negedge clk_in);                              // cycle s+1
        sif.wr_valid_in = 1'b0;
        check("pop_count_same", count_out, 1);
        check("pop_wr_adv", sif.wr_addr_out, 2);
        check("pop_rd_adv", sif.rd_addr_out, 1);
        repeat (15) @(negedge clk_in);                  // cycle s+16
        check("to_not_yet", timeout_out, 0);
        check("to_still_waiting", dut.state, WAIT_START);
        @(negedge clk_in);                              // cycle s+17
        check("to_flag", timeout_out, 1);
        check("to_idle", dut.state, IDLE);
        repeat (3) @(negedge clk_in);                   // cycle s+20
        check("to_next_send", {sif.tx_valid_out, sif.rd_addr_out}, {1'b1, 11'd1});
        for (int i = 0; i < 40 && dut.state != IDLE; i++) @(negedge clk_in);
        check("to_second_done", {dut.state == IDLE, empty_out, timeout_out}, 3'b111);

        // Asynchronous reset in WAIT_DONE with five letters pending.
        fill_to_wait_done("arst");
        check("arst_flags_set", {overflow_out, timeout_out}, 2'b11);
        #2 rst_in = 1'b1;
        #1 check_reset_vals("arst");
        @(negedge clk_in);
        rst_in = 1'b0;
        for (int i = 0; i < 80 && sif.tx_busy_in; i++) @(negedge clk_in);
        check("arst_busy_fell", sif.tx_busy_in, 0);

        // Synchronous clear in the same situation, with a coincident write.
        fill_to_wait_done("clr");
        check("clr_wr_addr6", sif.wr_addr_out, 6);
        clear_in        = 1'b1;
        sif.wr_valid_in = 1'b1;
        #1 check("clr_not_async", count_out, 5);
        @(negedge clk_in);
        clear_in        = 1'b0;
        sif.wr_valid_in = 1'b0;
        check_reset_vals("clr");

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
